// File: rtl/if_fetch_queue.sv
// In-order instruction-fetch queue between pre-IF and ID. It pairs bus responses with their PCs and drops stale responses after a flush.
// Optional build macro FS_BYPASS_EN: a response for the head entry is presented to ID in the same cycle it arrives.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pfs_valid,
  input  logic [PC_W-1:0]   pfs_pc,
  input  logic              pfs_req,
  input  logic              pfs_bd,
  output logic              fs_allowin,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              ds_allowin,
  output logic              ds_valid,
  output logic [PC_W-1:0]   ds_pc,
  output logic [INST_W-1:0] ds_inst,
  output logic              ds_ex,
  output logic [4:0]        ds_exccode,
  output logic [PC_W-1:0]   ds_badvaddr,
  output logic              ds_bd,
  input  logic              flush,
  output logic              fs_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [4:0]  EXC_ADEL = 5'h04;

  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     cancel_cnt_reg;
  logic [DEPTH-1:0]  filled_reg;
  logic [DEPTH-1:0]  ex_reg;
  logic [DEPTH-1:0]  req_reg;
  logic [DEPTH-1:0]  bd_reg;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0] head_idx;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] used;
  logic [CW:0]   occ;
  logic          empty;
  logic          full;

  assign head_idx = rd_ptr_reg[AW-1:0];
  assign wr_idx   = wr_ptr_reg[AW-1:0];
  assign used     = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (rd_ptr_reg == wr_ptr_reg);
  assign full     = (rd_ptr_reg[AW] != wr_ptr_reg[AW]) && (head_idx == wr_idx);
  // Cancelled responses still occupy bus slots, so they count against capacity.
  assign occ      = {1'b0, used} + {1'b0, cancel_cnt_reg};

  // Per-slot view in age order: slot gi is the gi-th oldest queued entry.
  logic [AW-1:0]    slot_idx [DEPTH];
  logic [DEPTH-1:0] in_q;
  logic [DEPTH-1:0] pend;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_idx[gi] = head_idx + AW'(gi);
      assign in_q[gi]     = (used > CW'(gi));
      assign pend[gi]     = in_q[gi] && req_reg[slot_idx[gi]] && !filled_reg[slot_idx[gi]];
    end
  endgenerate

  logic [CW-1:0] pend_cnt;
  logic          tgt_found;
  logic [AW-1:0] tgt_idx;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt = pend_cnt + CW'(pend[i]);
    end
  end

  // Oldest issued-but-unfilled entry receives the next live response.
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        tgt_found = 1'b1;
        tgt_idx   = slot_idx[i];
      end
    end
  end

  logic          resp_live;
  logic          fill_en;
  logic          push;
  logic          pop;
  logic          push_ex;
  logic          head_ok;
  logic [INST_W-1:0] head_inst;

  assign resp_live = inst_data_ok && (cancel_cnt_reg == '0) && !flush;
  assign fill_en   = resp_live && tgt_found;
  assign head_ok   = !empty && filled_reg[head_idx];
  assign push_ex   = (pfs_pc[1:0] != 2'b00) && !pfs_req;

`ifdef FS_BYPASS_EN
  logic bypass;
  assign bypass    = resp_live && pend[0];
  assign ds_valid  = head_ok || bypass;
  assign head_inst = bypass ? inst_rdata : inst_mem[head_idx];
`else
  assign ds_valid  = head_ok;
  assign head_inst = inst_mem[head_idx];
`endif

  assign fs_allowin = (occ < DEPTH_C) && !flush;
  assign push       = pfs_valid && fs_allowin;
  assign pop        = ds_valid && ds_allowin && !flush;
  assign fs_busy    = !empty || (cancel_cnt_reg != '0);

  // Head fields are masked to zero whenever nothing valid is presented.
  assign ds_ex       = ds_valid && ex_reg[head_idx];
  assign ds_pc       = ds_valid ? pc_mem[head_idx] : '0;
  assign ds_inst     = (ds_valid && !ds_ex) ? head_inst : '0;
  assign ds_exccode  = ds_ex ? EXC_ADEL : 5'h00;
  assign ds_badvaddr = ds_ex ? pc_mem[head_idx] : '0;
  assign ds_bd       = ds_valid && bd_reg[head_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      cancel_cnt_reg <= '0;
      filled_reg     <= '0;
      ex_reg         <= '0;
      req_reg        <= '0;
      bd_reg         <= '0;
    end else begin
      if (flush) begin
        rd_ptr_reg     <= wr_ptr_reg;
        cancel_cnt_reg <= cancel_cnt_reg + pend_cnt - CW'(inst_data_ok);
      end else begin
        if (inst_data_ok && (cancel_cnt_reg != '0)) begin
          cancel_cnt_reg <= cancel_cnt_reg - CW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
      end
      if (fill_en) begin
        filled_reg[tgt_idx] <= 1'b1;
      end
      if (push) begin
        filled_reg[wr_idx] <= push_ex;
        ex_reg[wr_idx]     <= push_ex;
        req_reg[wr_idx]    <= pfs_req;
        bd_reg[wr_idx]     <= pfs_bd;
      end
    end
  end

  // Payload storage needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx] <= pfs_pc;
    end
    if (fill_en) begin
      inst_mem[tgt_idx] <= inst_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(push && pfs_req && (pfs_pc[1:0] != 2'b00)));
      assert (!(push && full));
      assert (!(resp_live && !tgt_found));
      assert (!(flush && inst_data_ok && (cancel_cnt_reg == '0) && (pend_cnt == '0)));
    end
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry IF stage.
- Sits between pre-IF (request issue) and ID.
- Tracks up to DEPTH in-flight instruction fetches in an in-order queue. Pairs each inst-SRAM data_ok response with its PC, raises ADEL for misaligned PCs, and hands entries to ID in order.
- On flush (exception/eret), discards all queued entries and absorbs the stale responses still outstanding on the bus through a cancel counter.

Parameters:
- DEPTH, 4: queue entries and maximum outstanding fetches; power of 2, ≥2.
- PC_W, 32: PC width.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- pfs_valid  in  1  pre-IF pushes an entry this cycle.
- pfs_pc  in  PC_W  PC of pushed entry.
- pfs_req  in  1  pre-IF issued a bus request for this entry (0 means misaligned, no request).
- pfs_bd  in  1  entry is a branch delay slot.
- fs_allowin  out  1  queue accepts a push this cycle.
- inst_data_ok  in  1  in-order fetch response.
- inst_rdata  in  INST_W  response data.
- ds_allowin  in  1  ID accepts the head entry.
- ds_valid  out  1  head entry complete.
- ds_pc  out  PC_W  head PC.
- ds_inst  out  INST_W  head instruction; 0 when ds_ex is set.
- ds_ex  out  1  head carries ADEL.
- ds_exccode  out  5  5'h04 when ds_ex, else 0.
- ds_badvaddr  out  PC_W  head PC when ds_ex, else 0.
- ds_bd  out  1  head bd flag.
- flush  in  1  exception or eret flush.
- fs_busy  out  1  queue non-empty or cancel_cnt ≠ 0.

Behaviour:
- Queue storage:
  - Circular, DEPTH entries, one-bit-wider rd/wr pointers; full/empty from MSB compare.
  - Per entry: pc, inst, bd, ex, filled.
- Push: occurs when pfs_valid && fs_allowin && !flush.
  - fs_allowin = (used + cancel_cnt < DEPTH) && !flush, so total bus outstanding never exceeds DEPTH.
  - The entry is written at wr_ptr with ex = (pc[1:0] ≠ 0) && !pfs_req, filled = ex.
  - pfs_req=1 with a misaligned PC is illegal (checked by an assertion).
- Response (inst_data_ok):
  - If cancel_cnt ≠ 0: the response is discarded and cancel_cnt decrements.
  - Else: inst_rdata is written into the oldest entry with filled=0 and pfs_req=1, and that entry's filled is set.
  - A response with no such entry is illegal (assertion).
- Pop: occurs when ds_valid && ds_allowin.
  - ds_valid = !empty && head.filled.
  - ds_* outputs are driven from the head entry (registered storage). Latency from data_ok to ds_valid is 1 cycle.
- Flush:
  - All entries are invalidated (rd_ptr ← wr_ptr) in the same cycle; push and pop are suppressed.
  - cancel_cnt ← cancel_cnt + (issued-unfilled entries) − (data_ok this cycle ? 1 : 0). The data_ok in the flush cycle is discarded.
  - ds_valid is 0 in the cycle after flush.
- Simultaneous push, response and pop in one cycle: all take effect; the occupancy arithmetic uses the pre-cycle state.
- Counter widths:
  - used: clog2(DEPTH)+1 bits.
  - cancel_cnt: clog2(DEPTH)+1 bits, saturating at neither end. Overflow and underflow are unreachable by construction.
- Reset (asynchronous, resetn=0):
  - Pointers, filled bits and cancel_cnt are cleared.
  - Outputs: ds_valid=0, fs_allowin=1, fs_busy=0; ds_pc/ds_inst/ds_badvaddr/ds_exccode/ds_ex/ds_bd=0.
  - Outstanding responses at reset are not tracked; the bus is reset together with the block.

Optional Feature:
- FS_BYPASS_EN defined:
  - When the head is the oldest unfilled requested entry and inst_data_ok arrives with cancel_cnt=0, ds_valid=1 the same cycle.
  - ds_inst = inst_rdata combinationally; the entry pops that cycle if ds_allowin, otherwise it is written as usual.
- Undefined: data_ok-to-ds_valid latency is fixed at 1 cycle; outputs depend only on queue state.

Test Plan:
- Basic fetch:
  - Stimulus: push PCs 0xBFC00000, 0xBFC00004 (pfs_req=1); data_ok 0x24080001 then 0x24090002; ds_allowin=1.
  - Required: ds_valid one cycle after each response, pcs/insts in order, ds_ex=0.
- Back-pressure:
  - Stimulus: ds_allowin=0; push DEPTH=4 entries; return all responses.
  - Required: fs_allowin=0 after the 4th push. After ds_allowin=1, four consecutive pops in order; fs_allowin=1 after the first pop.
- ADEL:
  - Stimulus: push PC 0xBFC00006 with pfs_req=0, then 0xBFC00008 with pfs_req=1.
  - Required: head pops immediately with ds_ex=1, exccode=5'h04, badvaddr=0xBFC00006, inst=0. The next entry waits for its data_ok.
- Flush with outstanding requests:
  - Stimulus: 3 requests issued, 0 returned; flush; push 0xBFC00380; then 4 data_ok (0x11, 0x22, 0x33, 0x44).
  - Required: cancel_cnt=3; the first three responses are dropped; 0xBFC00380 delivered with inst 0x44.
- Flush coincident with data_ok:
  - Stimulus: 2 unfilled requests, data_ok and flush in the same cycle.
  - Required: cancel_cnt=1 (2 − 1); that response is not delivered; fs_allowin=0 during the flush cycle.
- Async reset mid-operation:
  - Stimulus: resetn=0 asserted between clock edges with 3 entries queued.
  - Required: ds_valid=0, fs_busy=0 and fs_allowin=1 immediately, before the next clk edge.
